mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 64: word count of data RAM; byte range 0 .. 4*MEM_WORDS-1.
REQ-002 Parameter MILESTONE_ADDR, default 80: byte address of the milestone store.
REQ-003 Parameter RESULT_ADDR, default 84: byte address of the final-result store.
REQ-004 Parameter EXPECT, default 7: required value for milestone and result stores.
REQ-005 Parameter STRICT, default 1: 1 = any store to an address other than MILESTONE_ADDR/RESULT_ADDR is a failure.
REQ-006 Parameter TIMEOUT, default 90: cycle budget after reset before a forced failure.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 memwrite  in  1  CPU store strobe, one cycle per store.
REQ-010 memread  in  1  CPU load strobe, one cycle per load.
REQ-011 dataaddr  in  32  CPU byte address.
REQ-012 writedata  in  32  CPU store data.
REQ-013 readdata  out  32  load data, registered.
REQ-014 ready  out  1  one-cycle pulse, readdata valid.
REQ-015 status  out  2  0 RUN, 1 MILESTONE, 2 PASS, 3 FAIL.
REQ-016 done  out  1  high in PASS or FAIL.
REQ-017 fail_addr  out  32  dataaddr of the failing access; 0xFFFFFFFF for timeout.
REQ-018 cycles  out  32  cycles since reset, frozen when done rises.

Function
REQ-019 RAM index = dataaddr[31:2]; in range iff index < MEM_WORDS.
REQ-020 Store while not done: in range, aligned, and permitted -> RAM[index] <= writedata at that edge.
REQ-021 Load: memread at edge N -> readdata = RAM[index] and ready = 1 during cycle N+1; ready is 0 otherwise.
REQ-022 Store then load of same word in consecutive cycles returns the new data.
REQ-023 Load with out-of-range index returns 0 with ready; not a failure.
REQ-024 FSM RUN: store to MILESTONE_ADDR with EXPECT -> MILESTONE; any other value -> FAIL.
REQ-025 RUN or MILESTONE: store to RESULT_ADDR with EXPECT -> PASS; any other value -> FAIL.
REQ-026 MILESTONE: repeated milestone store with EXPECT stays in MILESTONE; any other value -> FAIL.
REQ-027 Store with dataaddr[1:0] != 0 -> FAIL, no RAM write.
REQ-028 Store with out-of-range index -> FAIL.
REQ-029 STRICT=1: store to any in-range address other than MILESTONE_ADDR/RESULT_ADDR -> FAIL, no RAM write; STRICT=0: written normally, no state change.
REQ-030 memread and memwrite high in the same cycle -> FAIL; no write; no ready.
REQ-031 cycles increments each cycle while not done, saturating at 0xFFFFFFFF.
REQ-032 cycles reaching TIMEOUT while in RUN or MILESTONE -> FAIL, fail_addr = 0xFFFFFFFF; a store arriving in the same cycle is evaluated first, so a PASS on that edge wins.
REQ-033 fail_addr written only on the transition into FAIL; otherwise holds.
REQ-034 PASS and FAIL are sticky until reset; once done, stores are ignored, RAM is unchanged, and loads are still served.
REQ-035 On the edge of a state change, status and done update together, one cycle after the triggering strobe.

Reset
REQ-036 reset high at an edge: status = RUN, done = 0, ready = 0, readdata = 0, fail_addr = 0, cycles = 0; strobes in the same cycle are ignored.
REQ-037 RAM contents are not cleared by reset.
REQ-038 reset asserted mid-load suppresses the pending ready pulse.

Verification
REQ-039 Store 7 @80, then store 7 @84 -> status 1 after first store, then 2; done = 1; cycles frozen.
REQ-040 Store 5 @80 -> status 3, fail_addr = 80; a later store 7 @84 leaves status 3.
REQ-041 STRICT=0: store 0xDEADBEEF @12, then load @12 -> ready next cycle, readdata = 0xDEADBEEF; status 0.
REQ-042 STRICT=1: store @12 -> status 3, fail_addr = 12; store @82 -> status 3, fail_addr = 82.
REQ-043 No stores for 90 cycles -> status 3, fail_addr = 0xFFFFFFFF, cycles = 90.
REQ-044 Store 7 @80, then reset for one cycle -> status 0, cycles 0; memread + memwrite together -> status 3.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data RAM for a CPU under test, plus a small
// pass/fail monitor that watches milestone/result stores, enforces store
// rules and applies a cycle budget.
module mem_responder #(
  parameter int unsigned MEM_WORDS      = 64,
  parameter logic [31:0] MILESTONE_ADDR = 32'd80,
  parameter logic [31:0] RESULT_ADDR    = 32'd84,
  parameter logic [31:0] EXPECT         = 32'd7,
  parameter bit          STRICT         = 1'b1,
  parameter logic [31:0] TIMEOUT        = 32'd90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic [1:0]  status,
  output logic        done,
  output logic [31:0] fail_addr,
  output logic [31:0] cycles
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MILESTONE = 2'd1,
    ST_PASS      = 2'd2,
    ST_FAIL      = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fail_addr_reg, fail_addr_next;
  logic [31:0] cycles_reg, cycles_next, cycles_inc;
  logic [31:0] readdata_reg;
  logic        ready_reg;
  logic        done_w, in_range, wr_en, rd_en, fail_hit, pass_hit;
  logic [31:0] word_idx;
  logic [AW-1:0] ram_addr;

  logic [31:0] ram [MEM_WORDS];

  assign word_idx = {2'b00, dataaddr[31:2]};
  assign in_range = (word_idx < 32'(MEM_WORDS));
  assign ram_addr = dataaddr[AW+1:2];
  assign done_w   = (state_reg == ST_PASS) || (state_reg == ST_FAIL);

  // A load is served in any state, but a colliding store cancels it.
  assign rd_en    = memread && !memwrite && !reset;

  // Saturating cycle counter value for the next edge.
  assign cycles_inc = (cycles_reg == 32'hFFFF_FFFF) ? cycles_reg : cycles_reg + 32'd1;

  // Next-state, RAM write decision and fail address capture.
  always_comb begin
    state_next     = state_reg;
    fail_addr_next = fail_addr_reg;
    cycles_next    = cycles_reg;
    wr_en          = 1'b0;
    fail_hit       = 1'b0;
    pass_hit       = 1'b0;
    if (!done_w && !reset) begin
      cycles_next = cycles_inc;
      if (memwrite && memread) begin
        fail_hit = 1'b1;
      end else if (memwrite) begin
        if (dataaddr[1:0] != 2'b00) begin
          fail_hit = 1'b1;
        end else if (dataaddr == MILESTONE_ADDR) begin
          if (writedata == EXPECT) begin
            if (state_reg == ST_RUN) state_next = ST_MILESTONE;
            wr_en = in_range;
          end else begin
            fail_hit = 1'b1;
          end
        end else if (dataaddr == RESULT_ADDR) begin
          if (writedata == EXPECT) begin
            pass_hit   = 1'b1;
            state_next = ST_PASS;
            wr_en      = in_range;
          end else begin
            fail_hit = 1'b1;
          end
        end else if (!in_range) begin
          fail_hit = 1'b1;
        end else if (STRICT) begin
          fail_hit = 1'b1;
        end else begin
          wr_en = 1'b1;
        end
      end
      // The store on this edge is judged before the budget check.
      if (fail_hit) begin
        state_next     = ST_FAIL;
        fail_addr_next = dataaddr;
      end else if (!pass_hit && (cycles_inc >= TIMEOUT)) begin
        state_next     = ST_FAIL;
        fail_addr_next = 32'hFFFF_FFFF;
      end
    end
  end

  // Monitor state, fail address and cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      fail_addr_reg <= 32'd0;
      cycles_reg    <= 32'd0;
    end else begin
      state_reg     <= state_next;
      fail_addr_reg <= fail_addr_next;
      cycles_reg    <= cycles_next;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[ram_addr] <= writedata;
  end

  // Registered load data and its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= 32'd0;
      ready_reg    <= 1'b0;
    end else begin
      ready_reg <= rd_en;
      if (rd_en) readdata_reg <= in_range ? ram[ram_addr] : 32'd0;
    end
  end

  assign readdata  = readdata_reg;
  assign ready     = ready_reg;
  assign status    = state_reg;
  assign done      = done_w;
  assign fail_addr = fail_addr_reg;
  assign cycles    = cycles_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one strict instance (a) and one
// permissive instance (b) sharing clock, reset, address and data.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataaddr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        mw_a = 1'b0, mr_a = 1'b0, mw_b = 1'b0, mr_b = 1'b0;

  logic [31:0] readdata_a, fail_addr_a, cycles_a;
  logic [31:0] readdata_b, fail_addr_b, cycles_b;
  logic        ready_a, done_a, ready_b, done_b;
  logic [1:0]  status_a, status_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.STRICT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .memwrite(mw_a), .memread(mr_a),
    .dataaddr(dataaddr), .writedata(writedata),
    .readdata(readdata_a), .ready(ready_a), .status(status_a),
    .done(done_a), .fail_addr(fail_addr_a), .cycles(cycles_a)
  );

  mem_responder #(.STRICT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .memwrite(mw_b), .memread(mr_b),
    .dataaddr(dataaddr), .writedata(writedata),
    .readdata(readdata_b), .ready(ready_b), .status(status_b),
    .done(done_b), .fail_addr(fail_addr_b), .cycles(cycles_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge; one rising edge in between.
  task automatic store(input bit to_b, input logic [31:0] a, input logic [31:0] d);
    dataaddr = a; writedata = d;
    if (to_b) mw_b = 1'b1; else mw_a = 1'b1;
    @(negedge clk);
    mw_a = 1'b0; mw_b = 1'b0;
    $display("txn store %s addr=%h data=%h", to_b ? "b" : "a", a, d);
  endtask

  task automatic load(input bit to_b, input logic [31:0] a);
    dataaddr = a;
    if (to_b) mr_b = 1'b1; else mr_a = 1'b1;
    @(negedge clk);
    mr_a = 1'b0; mr_b = 1'b0;
    $display("txn load %s addr=%h", to_b ? "b" : "a", a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset");
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_status", {30'd0, status_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_readdata", readdata_a, 32'd0);
    check("rst_fail_addr", fail_addr_a, 32'd0);
    check("rst_cycles", cycles_a, 32'd0);

    // Permissive instance: ordinary stores and loads
    store(1'b1, 32'd12, 32'hDEAD_BEEF);
    check("b_store_status", {30'd0, status_b}, 32'd0);
    load(1'b1, 32'd12);
    check("b_load_ready", {31'd0, ready_b}, 32'd1);
    check("b_load_data", readdata_b, 32'hDEAD_BEEF);
    idle(1);
    check("b_ready_pulse_end", {31'd0, ready_b}, 32'd0);
    store(1'b1, 32'd16, 32'h0000_1234);
    load(1'b1, 32'd16);
    check("b_raw_data", readdata_b, 32'h0000_1234);
    load(1'b1, 32'h400);
    check("b_oor_load_ready", {31'd0, ready_b}, 32'd1);
    check("b_oor_load_data", readdata_b, 32'd0);
    check("b_oor_load_status", {30'd0, status_b}, 32'd0);
    store(1'b1, 32'h100, 32'd1);
    check("b_oor_store_status", {30'd0, status_b}, 32'd3);
    check("b_oor_store_faddr", fail_addr_b, 32'h100);
    check("a_idle_cycles", cycles_a, 32'd7);
    check("a_idle_status", {30'd0, status_a}, 32'd0);

    // Milestone then result
    do_reset();
    store(1'b0, 32'd80, 32'd7);
    check("ms_status", {30'd0, status_a}, 32'd1);
    check("ms_done", {31'd0, done_a}, 32'd0);
    store(1'b0, 32'd84, 32'd7);
    check("pass_status", {30'd0, status_a}, 32'd2);
    check("pass_done", {31'd0, done_a}, 32'd1);
    check("pass_cycles", cycles_a, 32'd2);
    idle(3);
    store(1'b0, 32'd84, 32'd5);
    check("pass_sticky", {30'd0, status_a}, 32'd2);
    check("pass_frozen", cycles_a, 32'd2);
    load(1'b0, 32'd80);
    check("done_load_ready", {31'd0, ready_a}, 32'd1);
    check("done_load_data", readdata_a, 32'd7);

    // Wrong milestone value
    do_reset();
    store(1'b0, 32'd80, 32'd5);
    check("badms_status", {30'd0, status_a}, 32'd3);
    check("badms_faddr", fail_addr_a, 32'd80);
    store(1'b0, 32'd84, 32'd7);
    check("badms_sticky", {30'd0, status_a}, 32'd3);
    check("badms_faddr_hold", fail_addr_a, 32'd80);

    // Strict address and alignment failures
    do_reset();
    store(1'b0, 32'd12, 32'd1);
    check("strict_status", {30'd0, status_a}, 32'd3);
    check("strict_faddr", fail_addr_a, 32'd12);
    do_reset();
    store(1'b0, 32'd82, 32'd7);
    check("misalign_status", {30'd0, status_a}, 32'd3);
    check("misalign_faddr", fail_addr_a, 32'd82);

    // Timeout
    do_reset();
    idle(89);
    check("to_pre_status", {30'd0, status_a}, 32'd0);
    check("to_pre_cycles", cycles_a, 32'd89);
    idle(1);
    check("to_status", {30'd0, status_a}, 32'd3);
    check("to_faddr", fail_addr_a, 32'hFFFF_FFFF);
    check("to_cycles", cycles_a, 32'd90);
    idle(5);
    check("to_frozen", cycles_a, 32'd90);

    // Reset after milestone, then read/write collision
    do_reset();
    store(1'b0, 32'd80, 32'd7);
    check("ms2_status", {30'd0, status_a}, 32'd1);
    do_reset();
    check("rst2_status", {30'd0, status_a}, 32'd0);
    check("rst2_cycles", cycles_a, 32'd0);
    dataaddr = 32'd84; writedata = 32'd7; mw_a = 1'b1; mr_a = 1'b1;
    @(negedge clk);
    mw_a = 1'b0; mr_a = 1'b0;
    $display("txn collide a addr=%h", dataaddr);
    check("coll_status", {30'd0, status_a}, 32'd3);
    check("coll_faddr", fail_addr_a, 32'd84);
    check("coll_ready", {31'd0, ready_a}, 32'd0);

    // Load strobe coinciding with reset gives no ready
    reset = 1'b1; mr_a = 1'b1; dataaddr = 32'd80;
    @(negedge clk);
    reset = 1'b0; mr_a = 1'b0;
    $display("txn load+reset a addr=%h", dataaddr);
    check("rstload_ready", {31'd0, ready_a}, 32'd0);
    check("rstload_status", {30'd0, status_a}, 32'd0);
    check("rstload_readdata", readdata_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
